instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'h0: fetch address loaded on reset.
REQ-002 Parameter MEM_BYTES, default 132: instruction memory size in bytes; fetch is legal only when pc+3 <= MEM_BYTES-1.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 Inst_Address  out  64: byte address to instruction memory; equals current pc.
REQ-006 Instruction  in  32: little-endian word returned combinationally by instruction memory for Inst_Address.
REQ-007 redirect_valid  in  1: branch/jump taken; flush and refetch.
REQ-008 redirect_target  in  64: new pc when redirect_valid=1.
REQ-009 out_valid  out  1: head entry valid toward decode.
REQ-010 out_ready  in  1: decode accepts head entry this cycle.
REQ-011 out_instr  out  32: head entry instruction.
REQ-012 out_pc  out  64: head entry pc.
REQ-013 halted  out  1: halt instruction fetched; fetching stopped.
REQ-014 fault  out  1: sticky misaligned or out-of-range fetch.
REQ-015 fetch_count  out  32: number of entries pushed since reset.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_instr/out_pc = head entry; pop occurs when out_valid && out_ready.
REQ-017 The FSM SHALL have states RUN, HALT and FAULT; reset enters RUN.
REQ-018 In RUN with no redirect, a push of {pc, Instruction} SHALL occur when count < 2, or count == 2 and a pop occurs the same cycle; a push SHALL advance pc by 4.
REQ-019 When no push occurs in RUN, pc and Inst_Address SHALL hold.
REQ-020 Latency: the entry fetched in cycle N SHALL appear on out_* in cycle N+1 when the FIFO was empty.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve program order.
REQ-022 When redirect_valid=1 in RUN or HALT, the FIFO SHALL be flushed (count=0, out_valid=0 next cycle), pc SHALL be loaded from redirect_target, no push SHALL occur that cycle, and the state SHALL become RUN; redirect overrides a concurrent pop and push.
REQ-023 When redirect_target[1:0] != 0, the FIFO SHALL be flushed and the state SHALL become FAULT with fault=1.
REQ-024 When a push is due and pc+3 > MEM_BYTES-1 or pc[1:0] != 0, no push SHALL occur, the state SHALL become FAULT, and pc SHALL hold.
REQ-025 Halt: when the pushed Instruction == 32'h00000063 (beq x0,x0,0), the entry SHALL be pushed, pc SHALL advance, the state SHALL become HALT, and halted SHALL read 1 from the next cycle.
REQ-026 In HALT and FAULT, no push SHALL occur; the FIFO SHALL continue draining through out_ready.
REQ-027 In FAULT, redirect_valid SHALL be ignored; only reset exits FAULT.
REQ-028 fetch_count SHALL increment by 1 on every push and wrap modulo 2^32.
REQ-029 pc arithmetic SHALL be 64-bit unsigned with wrap; the range check SHALL use the unwrapped comparison pc > MEM_BYTES-4.

Reset
REQ-030 On reset: pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, fetch_count=0, state=RUN.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents, pending halt and fault in the same edge, with no push on that edge.

Verification
REQ-032 Reset, then out_ready=1, memory word at 0 = 0x00A00293 -> cycle 1: out_valid=1, out_pc=0, out_instr=0x00A00293; cycle 2: out_pc=4.
REQ-033 out_ready=0 for 5 cycles after reset -> count=2, Inst_Address held at 8, fetch_count=2; then out_ready=1 -> out_pc sequence 0,4,8,12 with no duplicate or gap.
REQ-034 FIFO holding pcs 4,8 with redirect_valid=1, redirect_target=0x20, out_ready=1 -> next cycle out_valid=0, Inst_Address=0x20; following cycle out_pc=0x20.
REQ-035 redirect_target=0x22 -> fault=1, out_valid=0, no further pushes; a later redirect to 0x0 is ignored until reset.
REQ-036 Memory returns 0x00000063 at pc 0x10 -> entry pushed with out_pc=0x10, halted=1, fetch_count stops; redirect to 0x0 -> halted=0, fetch resumes at 0.
REQ-037 MEM_BYTES=132, straight-line fetch -> last push at pc 0x80; at pc 0x84 fault=1, and entries up to 0x80 drain normally.

Source files
------------

// File: rtl/instruction_fetch_controller_if.sv
// Fetch-side bundle: instruction memory port, redirect request and the
// decode-facing output queue head plus status.
interface instruction_fetch_controller_if;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    // Environment side: drives memory data, redirects and decode ready.
    modport master (
        input  Inst_Address, out_valid, out_instr, out_pc, halted, fault, fetch_count,
        output Instruction, redirect_valid, redirect_target, out_ready
    );

    // Fetch controller side.
    modport slave (
        output Inst_Address, out_valid, out_instr, out_pc, halted, fault, fetch_count,
        input  Instruction, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: walks pc through instruction memory, queues
// fetched words in a 2-entry FIFO toward decode, handles redirects, stops on
// the halt word (beq x0,x0,0) and latches a sticky fault on bad fetches.
module instruction_fetch_controller #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 132
) (
    input  logic                         clk,
    input  logic                         reset,
    instruction_fetch_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] HALT_INSTR = 32'h0000_0063;
    // Last legal byte address, kept 65 bits wide so pc+3 cannot wrap in the compare.
    localparam logic [64:0] LAST_BYTE  = 65'(MEM_BYTES) - 65'd1;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [1:0]  cnt_q;
    logic [63:0] pc0_q;      // head entry
    logic [31:0] instr0_q;
    logic [63:0] pc1_q;      // second entry
    logic [31:0] instr1_q;
    logic [31:0] fetch_count_q;

    logic pop_s;
    logic room_s;
    logic fetch_bad_s;
    logic redirect_s;
    logic push_s;
    logic fault_fetch_s;

    // Decide this cycle's pop, push, redirect and bad-fetch conditions.
    always_comb begin
        pop_s       = (cnt_q != 2'd0) && bus.out_ready;
        room_s      = (cnt_q != 2'd2) || pop_s;
        fetch_bad_s = (({1'b0, pc_q} + 65'd3) > LAST_BYTE) || (pc_q[1:0] != 2'b00);
        redirect_s  = bus.redirect_valid && (state_q != ST_FAULT);
        if ((state_q == ST_RUN) && !bus.redirect_valid && room_s) begin
            push_s        = !fetch_bad_s;
            fault_fetch_s = fetch_bad_s;
        end else begin
            push_s        = 1'b0;
            fault_fetch_s = 1'b0;
        end
    end

    // Fetch state machine, pc, FIFO storage and push counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            cnt_q         <= 2'd0;
            pc0_q         <= 64'd0;
            instr0_q      <= 32'd0;
            pc1_q         <= 64'd0;
            instr1_q      <= 32'd0;
            fetch_count_q <= 32'd0;
        end else if (redirect_s) begin
            // Redirect flushes the queue and wins over any pop or push.
            cnt_q <= 2'd0;
            pc_q  <= bus.redirect_target;
            if (bus.redirect_target[1:0] != 2'b00) begin
                state_q <= ST_FAULT;
            end else begin
                state_q <= ST_RUN;
            end
        end else begin
            if (push_s) begin
                pc_q          <= pc_q + 64'd4;
                fetch_count_q <= fetch_count_q + 32'd1;
                if (bus.Instruction == HALT_INSTR) begin
                    state_q <= ST_HALT;
                end else begin
                    state_q <= state_q;
                end
            end else if (fault_fetch_s) begin
                state_q <= ST_FAULT;
            end else begin
                state_q <= state_q;
            end

            // Shift-register FIFO: entry 0 is always the head.
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        pc0_q    <= pc_q;
                        instr0_q <= bus.Instruction;
                    end else begin
                        pc1_q    <= pc_q;
                        instr1_q <= bus.Instruction;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    pc0_q    <= pc1_q;
                    instr0_q <= instr1_q;
                    cnt_q    <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        pc0_q    <= pc_q;
                        instr0_q <= bus.Instruction;
                    end else begin
                        pc0_q    <= pc1_q;
                        instr0_q <= instr1_q;
                        pc1_q    <= pc_q;
                        instr1_q <= bus.Instruction;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign bus.Inst_Address = pc_q;
    assign bus.out_valid    = (cnt_q != 2'd0);
    assign bus.out_instr    = instr0_q;
    assign bus.out_pc       = pc0_q;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.fault        = (state_q == ST_FAULT);
    assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller with a behavioural
// instruction memory and an in-order scoreboard of expected {pc, instr}.
module tb_instruction_fetch_controller;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset;
    logic [31:0] mem [0:32];
    exp_t sb[$];
    exp_t e;
    int checks;
    int failures;

    instruction_fetch_controller_if bus();

    instruction_fetch_controller #(
        .RESET_PC  (64'h0),
        .MEM_BYTES (132)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; reads outside the array return zero.
    always_comb begin
        if (bus.Inst_Address < 64'd132) begin
            bus.Instruction = mem[int'(bus.Inst_Address[7:2])];
        end else begin
            bus.Instruction = 32'h0;
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 64'h0;
        bus.out_ready       = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        exp_t x;
        x.pc    = pc;
        x.instr = mem[int'(pc[7:2])];
        sb.push_back(x);
    endtask

    task automatic test_reset;
        do_reset();
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_fifo: valid=%b pc=%h instr=%h, expected 0/0/0", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        checks++;
        if (bus.Inst_Address !== 64'h0 || bus.fetch_count !== 32'd0 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: addr=%h cnt=%0d halted=%b fault=%b, expected 0/0/0/0", bus.Inst_Address, bus.fetch_count, bus.halted, bus.fault);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_fetch;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) expect_pc(64'(4 * k));
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h00A00293) begin
            failures++;
            $display("FAIL first_latency: valid=%b pc=%h instr=%h, expected 1/0/00a00293", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL ff_extra: unexpected pc=%h", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                        failures++;
                        $display("FAIL ff_order: got pc=%h instr=%h, expected pc=%h instr=%h", bus.out_pc, bus.out_instr, e.pc, e.instr);
                    end
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL ff_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.Inst_Address !== 64'h8 || bus.fetch_count !== 32'd2 || bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin
            failures++;
            $display("FAIL bp_hold: addr=%h cnt=%0d valid=%b pc=%h, expected 8/2/1/0", bus.Inst_Address, bus.fetch_count, bus.out_valid, bus.out_pc);
        end
        for (int k = 0; k < 4; k++) expect_pc(64'(4 * k));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra: unexpected pc=%h", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                        failures++;
                        $display("FAIL bp_order: got pc=%h instr=%h, expected pc=%h instr=%h", bus.out_pc, bus.out_instr, e.pc, e.instr);
                    end
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_redirect;
        do_reset();
        step();
        step();
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_pc !== 64'h4 || bus.Inst_Address !== 64'hC) begin
            failures++;
            $display("FAIL rd_setup: head=%h addr=%h, expected 4/c", bus.out_pc, bus.Inst_Address);
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 64'h20;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.Inst_Address !== 64'h20) begin
            failures++;
            $display("FAIL rd_flush: valid=%b addr=%h, expected 0/20", bus.out_valid, bus.Inst_Address);
        end
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h20 || bus.out_instr !== mem[8] || bus.fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL rd_refetch: valid=%b pc=%h instr=%h cnt=%0d, expected 1/20/%h/4", bus.out_valid, bus.out_pc, bus.out_instr, bus.fetch_count, mem[8]);
        end
    endtask

    task automatic test_fault_redirect;
        do_reset();
        bus.out_ready = 1'b1;
        step();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 64'h22;
        step();
        checks++;
        if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flt_set: fault=%b valid=%b, expected 1/0", bus.fault, bus.out_valid);
        end
        bus.redirect_valid = 1'b0;
        step();
        step();
        checks++;
        if (bus.fetch_count !== 32'd2 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flt_nopush: cnt=%0d valid=%b, expected 2/0", bus.fetch_count, bus.out_valid);
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 64'h0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.fetch_count !== 32'd2) begin
            failures++;
            $display("FAIL flt_sticky: fault=%b valid=%b cnt=%0d, expected 1/0/2", bus.fault, bus.out_valid, bus.fetch_count);
        end
        do_reset();
        checks++;
        if (bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL flt_clear: fault=%b, expected 0", bus.fault);
        end
    endtask

    task automatic test_halt;
        logic exp_halt;
        mem[4] = 32'h0000_0063;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_pc(64'(4 * k));
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_halt = (i >= 5);
            checks++;
            if (bus.halted !== exp_halt) begin
                failures++;
                $display("FAIL halt_flag: cycle %0d halted=%b, expected %b", i, bus.halted, exp_halt);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL halt_extra: unexpected pc=%h", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                        failures++;
                        $display("FAIL halt_order: got pc=%h instr=%h, expected pc=%h instr=%h", bus.out_pc, bus.out_instr, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || bus.fetch_count !== 32'd5 || bus.Inst_Address !== 64'h14 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_stop: left=%0d cnt=%0d addr=%h valid=%b, expected 0/5/14/0", sb.size(), bus.fetch_count, bus.Inst_Address, bus.out_valid);
        end
        mem[4] = 32'hA000_0004;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 64'h0;
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.halted !== 1'b0 || bus.Inst_Address !== 64'h0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_exit: halted=%b addr=%h valid=%b, expected 0/0/0", bus.halted, bus.Inst_Address, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.fetch_count !== 32'd6) begin
            failures++;
            $display("FAIL halt_resume: valid=%b pc=%h cnt=%0d, expected 1/0/6", bus.out_valid, bus.out_pc, bus.fetch_count);
        end
    endtask

    task automatic test_mem_end;
        logic exp_fault;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 32; k++) expect_pc(64'(4 * k));
        for (int i = 1; i <= 40; i++) begin
            step();
            exp_fault = (i >= 34);
            if (bus.fault !== exp_fault) begin
                checks++;
                failures++;
                $display("FAIL end_fault: cycle %0d fault=%b, expected %b", i, bus.fault, exp_fault);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL end_extra: unexpected pc=%h", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                        failures++;
                        $display("FAIL end_order: got pc=%h instr=%h, expected pc=%h instr=%h", bus.out_pc, bus.out_instr, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || bus.fault !== 1'b1 || bus.fetch_count !== 32'd33 || bus.Inst_Address !== 64'h84 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL end_final: left=%0d fault=%b cnt=%0d addr=%h valid=%b, expected 0/1/33/84/0", sb.size(), bus.fault, bus.fetch_count, bus.Inst_Address, bus.out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 64'h0;
        bus.out_ready       = 1'b0;
        for (int i = 0; i <= 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h00A0_0293;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_fault_redirect();
        test_halt();
        test_mem_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
